// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: requests the bus, shifts one byte out on the
// device-generated clock, checks the device acknowledge, and reports done/error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int REQ_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       done,
  output logic       error,
  output logic [2:0] dbg_state
);

  // Handshake: a byte is accepted on any clock edge where tx_valid && tx_ready;
  // tx_valid is ignored while tx_ready is low, nothing is queued.

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CW = $clog2(max3(INHIBIT_CYCLES, REQ_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_WAIT_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic [3:0]    n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          ready_q, ready_d;
  logic [1:0]    clk_s_q, dat_s_q;
  logic          clk_prev_q;
  logic          fe;

  // Synchronisers reset to the idle (pulled-up) bus level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_s_q    <= {clk_s_q[0], ps2_clk_in};
      dat_s_q    <= {dat_s_q[0], ps2_dat_in};
      clk_prev_q <= clk_s_q[1];
    end
  end

  assign fe = clk_prev_q & ~clk_s_q[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      par_q    <= 1'b0;
      n_q      <= '0;
      cnt_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      par_q    <= par_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      error_q  <= error_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    par_d    = par_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_valid && ready_q) begin
          sr_d    = tx_data;
          par_d   = ~^tx_data;
          n_d     = '0;
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REQ: begin
        if (cnt_q == REQ_LAST) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND, S_WAIT_ACK, S_WAIT_IDLE: begin
        // Timeout is checked first so it wins over a falling edge in the same cycle.
        if (cnt_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == S_SEND) begin
            if (fe) begin
              n_d = n_q + 4'd1;
              if (n_q < 4'd8) begin
                dat_oe_d = ~sr_q[n_q[2:0]];
              end else if (n_q == 4'd8) begin
                dat_oe_d = ~par_q;
              end else begin
                dat_oe_d = 1'b0;
                state_d  = S_WAIT_ACK;
              end
            end
          end else if (state_q == S_WAIT_ACK) begin
            if (fe) begin
              if (!dat_s_q[1]) begin
                state_d = S_WAIT_IDLE;
              end else begin
                error_d = 1'b1;
                state_d = S_IDLE;
              end
            end
          end else begin
            if (clk_s_q[1] && dat_s_q[1]) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    if (state_d == S_IDLE || state_d == S_INHIBIT) dat_oe_d = 1'b0;
    if (state_d == S_REQ) dat_oe_d = 1'b1;
    // tx_ready stays low through the done/error pulse cycle.
    ready_d = (state_d == S_IDLE) && !done_d && !error_d;
  end

  assign tx_ready   = ready_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign done       = done_q;
  assign error      = error_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector pin model, behavioural PS/2 device,
// expected-frame and expected-response queues checked by independent monitors.
module tb_ps2_host_tx;

  logic       clk;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       done;
  logic       error;
  logic [2:0] dbg_state;

  logic dev_clk_low;
  logic dev_dat_low;
  logic dev_enable;
  logic dev_ack;
  int   dev_abort_at;
  logic abort_hit;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [9:0] exp_frame_q[$];
  logic [1:0] exp_resp_q[$];   // {error, done}

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .REQ_CYCLES    (4),
    .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  logic pulse_seen = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      if (pulse_seen) chk("ready_after_pulse", tx_ready, 1);
      if (done || error) begin
        if (exp_resp_q.size() == 0) begin
          chk("unexpected_pulse", {error, done}, 2'b00);
        end else begin
          chk("response", {error, done}, exp_resp_q.pop_front());
        end
        chk("lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("ready_low_in_pulse", tx_ready, 0);
        if (done) done_cnt++;
      end
      pulse_seen = done || error;
    end else begin
      pulse_seen = 1'b0;
    end
  end

  // Device model: clocks 11 edges at a 200-cycle period once the host requests.
  initial begin
    logic [9:0] got;
    logic       aborted;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    abort_hit   = 1'b0;
    forever begin
      @(negedge clk);
      if (dev_enable && resetn && ps2_clk_in && !ps2_dat_in && !ps2_clk_oe) begin
        got = '0;
        aborted = 1'b0;
        repeat (50) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          dev_clk_low = 1'b1;
          repeat (100) @(negedge clk);
          if (dev_abort_at == i + 1) begin
            abort_hit = 1'b1;
            aborted = 1'b1;
            break;
          end
          dev_clk_low = 1'b0;
          got[i] = ps2_dat_in;
          repeat (100) @(negedge clk);
        end
        if (aborted) begin
          wait (abort_hit == 1'b0);
          dev_clk_low = 1'b0;
        end else begin
          if (exp_frame_q.size() == 0) chk("unexpected_frame", {22'd0, got}, 32'hffff_ffff);
          else chk("frame", {22'd0, got}, {22'd0, exp_frame_q.pop_front()});
          repeat (50) @(negedge clk);
          if (dev_ack) dev_dat_low = 1'b1;
          repeat (50) @(negedge clk);
          dev_clk_low = 1'b1;
          repeat (100) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (50) @(negedge clk);
          dev_dat_low = 1'b0;
        end
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((exp_resp_q.size() != 0 || !tx_ready) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < 20000), 1);
    repeat (250) @(negedge clk);
  endtask

  initial begin
    int n;
    int t0;
    int d0;
    resetn       = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    dev_enable   = 1'b1;
    dev_ack      = 1'b1;
    dev_abort_at = 0;

    #22;
    chk("rst_ready", tx_ready, 1);
    chk("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    chk("rst_pulses", {done, error}, 2'b00);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED: check request timing, then frame and ack
    exp_frame_q.push_back(10'h3ED);
    exp_resp_q.push_back(2'b01);
    send(8'hED);
    chk("accept_clk_oe", ps2_clk_oe, 1);
    chk("accept_dat_oe", ps2_dat_oe, 0);
    chk("accept_busy", tx_ready, 0);
    n = 0;
    while (!ps2_dat_oe && n < 100) begin @(negedge clk); n++; end
    chk("inhibit_len", n, 20);
    chk("req_clk_oe", ps2_clk_oe, 1);
    n = 0;
    while (ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
    chk("req_len", n, 4);
    chk("start_bit", ps2_dat_oe, 1);
    wait_quiet("wait_ed");

    // 0x01: parity bit 0
    exp_frame_q.push_back(10'h201);
    exp_resp_q.push_back(2'b01);
    send(8'h01);
    wait_quiet("wait_01");

    // 0xFF without acknowledge
    dev_ack = 1'b0;
    exp_frame_q.push_back(10'h3FF);
    exp_resp_q.push_back(2'b10);
    send(8'hFF);
    wait_quiet("wait_ff");
    dev_ack = 1'b1;

    // Device silent: timeout 5000 cycles after clock release
    dev_enable = 1'b0;
    exp_resp_q.push_back(2'b10);
    send(8'h3C);
    n = 0;
    while (ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (!error && n < 6000) begin @(negedge clk); n++; end
    chk("timeout_len", cyc - t0, 5000);
    wait_quiet("wait_timeout");
    dev_enable = 1'b1;

    // tx_valid held through a busy transfer
    d0 = done_cnt;
    exp_frame_q.push_back(10'h3AA);
    exp_resp_q.push_back(2'b01);
    @(negedge clk);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h55;
    exp_frame_q.push_back(10'h355);
    exp_resp_q.push_back(2'b01);
    n = 0;
    while (!tx_ready && n < 20000) begin @(negedge clk); n++; end
    chk("b2b_ready_back", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("b2b_second_accept", {tx_ready, ps2_clk_oe}, 2'b01);
    wait_quiet("wait_b2b");
    chk("b2b_done_count", done_cnt - d0, 2);

    // Reset after the 5th falling edge
    dev_abort_at = 5;
    send(8'h13);
    n = 0;
    while (!abort_hit && n < 10000) begin @(negedge clk); n++; end
    chk("abort_reached", abort_hit, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    chk("midrst_pulses", {done, error}, 2'b00);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    dev_abort_at = 0;
    abort_hit = 1'b0;
    @(negedge clk);
    chk("midrst_ready", tx_ready, 1);
    repeat (300) @(negedge clk);

    // 0xF4 after the reset completes normally
    exp_frame_q.push_back(10'h2F4);
    exp_resp_q.push_back(2'b01);
    send(8'hF4);
    wait_quiet("wait_f4");

    chk("frames_left", exp_frame_q.size(), 0);
    chk("resps_left", exp_resp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: it sends one command byte to the keyboard, for example LED set (0xED) or reset (0xFF). It is the opposite direction of the keyboard receive path and shares the same PS2_CLK/PS2_DAT pins. It implements the bus request, the device-clocked serial shift-out, and the acknowledge check. Lines are open-collector: the block only drives low through output enables, and the top level ties each pin to `oe ? 1'b0 : 1'bz`.

## Interface
Parameters:
- INHIBIT_CYCLES, 6000: clock-low request time, 120 µs at 50 MHz.
- REQ_CYCLES, 50: time data is held low while clock is still held low, before clock release.
- TIMEOUT_CYCLES, 750000: maximum cycles from clock release to transfer completion (15 ms).

Ports:
- clk  in  1  system clock (CLOCK_50). One clock domain.
- resetn  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte; sampled on accept.
- tx_valid  in  1  request to send.
- tx_ready  out  1  high only in IDLE. Accept occurs when tx_valid && tx_ready.
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- done  out  1  one-cycle pulse: byte sent and acknowledged.
- error  out  1  one-cycle pulse: no acknowledge, or timeout.

## Operation
Input synchronisation:
- Both pin inputs pass through a 2-flop synchroniser.
- Falling edge `fe` = previous synchronised clock 1 and current synchronised clock 0.

Accept:
- Latch tx_data into shift register sr.
- Compute parity p = ~^tx_data (odd parity).
- Clear edge counter n (4 bits) and the timing counter.

States:
- IDLE: both oe = 0, tx_ready = 1. On accept → INHIBIT.
- INHIBIT: clk_oe = 1, dat_oe = 0, for exactly INHIBIT_CYCLES cycles → REQ.
- REQ: clk_oe = 1, dat_oe = 1 (start bit), for exactly REQ_CYCLES cycles → SEND. Timeout counter is cleared on exit.
- SEND: clk_oe = 0, so the device now generates the clock. On each fe, n increments and the data line is driven as follows:
  - n = 1..8: dat_oe = ~sr[n-1], data sent LSB first.
  - n = 9: dat_oe = ~p.
  - n = 10: dat_oe = 0 (stop bit, line released); then → WAIT_ACK.
- WAIT_ACK: on fe (the 11th), sample synchronised data.
  - 0 → WAIT_IDLE.
  - 1 → error pulse, → IDLE.
- WAIT_IDLE: wait until synchronised clock and data are both 1, then pulse done and go → IDLE.

Timeout:
- The counter runs in SEND, WAIT_ACK and WAIT_IDLE.
- On reaching TIMEOUT_CYCLES: release both lines, pulse error, → IDLE.
- Timeout takes priority over a same-cycle fe.

Other rules:
- tx_valid is ignored outside IDLE; there is no queueing.
- done and error are mutually exclusive and never assert in the same transfer.
- Counter widths must cover their parameters: 20 bits at the defaults.

## Timing
- Reset (asynchronous) forces state IDLE, ps2_clk_oe = 0, ps2_dat_oe = 0, done = 0, error = 0, tx_ready = 1, n = 0.
- Reset mid-transfer releases both lines immediately, and no done or error is emitted.
- Accept at edge k:
  - tx_ready = 0 and clk_oe = 1 from k+1.
  - dat_oe = 1 from k+1+INHIBIT_CYCLES.
  - clk_oe = 0 from k+1+INHIBIT_CYCLES+REQ_CYCLES.
- Data-line update follows the pin's falling edge by 3 clk cycles (2 synchroniser cycles plus 1 register). This is well inside the device's ≥30 µs clock-low phase.
- done and error pulses are exactly one cycle wide. tx_ready returns to 1 in the cycle after the pulse.
- Back-to-back: a new accept is possible in the cycle tx_ready returns high.
- All outputs are registered; there are no combinational paths from pins to outputs.

## Test plan
Bench uses INHIBIT_CYCLES=20, REQ_CYCLES=4, TIMEOUT_CYCLES=5000. The device model clocks at a 200-cycle period after seeing clock released with data low.

- Send 0xED:
  - clock held low 20 cycles, then data low for 4 cycles before clock release.
  - bits sampled on device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - device acks low → one done pulse, tx_ready = 1.
- Send 0x01: parity bit 0 → done.
- Send 0xFF: parity 1; device withholds ack (data stays 1 on 11th edge) → error pulse, no done, both oe = 0.
- Device never clocks → error exactly 5000 cycles after clock release; lines released.
- tx_valid held high with 0xAA then 0x55 while busy:
  - only 0xAA is transmitted;
  - 0x55 is accepted only after tx_ready returns, giving two done pulses total.
- resetn low after the 5th falling edge → both oe = 0 within the same cycle, no done or error, tx_ready = 1 after release; the next 0xF4 send completes normally.
